// File: rtl/spi_ram_loader_if.sv
// spi_ram_loader_if: groups the SPI pins and the RAM port of the loader.
// The slave modport is the loader's view. The master modport is the view of
// the SPI host plus the RAM.
interface spi_ram_loader_if #(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32
);
    logic                      SCK;
    logic                      CS_N;
    logic                      MOSI;
    logic                      MISO;
    logic                      RAM_EN;
    logic [3:0]                RAM_WE;
    logic [ADDRESS_LENGTH-1:0] RAM_A;
    logic [DATA_LENGTH-1:0]    RAM_Di;
    logic [DATA_LENGTH-1:0]    RAM_Do;

    modport slave (
        input  SCK, CS_N, MOSI, RAM_Do,
        output MISO, RAM_EN, RAM_WE, RAM_A, RAM_Di
    );

    modport master (
        output SCK, CS_N, MOSI, RAM_Do,
        input  MISO, RAM_EN, RAM_WE, RAM_A, RAM_Di
    );
endinterface

// File: rtl/spi_ram_loader.sv
// spi_ram_loader: mode-0 SPI slave, oversampled in the CLK domain. It loads
// 32-bit words into the instruction/data RAM and stalls the core (ACTIVE)
// while a frame is in flight.
// A frame is: 8-bit command, 16-bit start word address, then N x 32-bit words.
// Optional readback (command 0x03) is built when SPI_LOADER_READBACK_EN is
// defined. Without it, 0x03 is ignored like any other unknown command and
// MISO is tied low.
module spi_ram_loader #(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    spi_ram_loader_if.slave      bus,
    output logic                 ACTIVE,
    output logic [15:0]          WORD_CNT
);

    localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef SPI_LOADER_READBACK_EN
    localparam logic [7:0] CMD_READ  = 8'h03;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WRITE,
`ifdef SPI_LOADER_READBACK_EN
        S_RDREQ,
        S_RDLOAD,
        S_RDATA,
`endif
        S_IGNORE
    } state_t;

    state_t state_q, state_d;

    // Input synchronizers. The third SCK/CS_N stage exists only for edge
    // detection.
    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;
    logic sck_rise;
    logic cs_fall;

    logic [4:0]                bit_cnt_q;
    logic [DATA_LENGTH-1:0]    shift_q;
    logic [DATA_LENGTH-1:0]    shift_in;
    logic [ADDRESS_LENGTH-1:0] addr_q;
    logic [ADDRESS_LENGTH-1:0] ram_a_q;
    logic [DATA_LENGTH-1:0]    ram_di_q;
    logic                      active_q;
    logic [15:0]               word_cnt_q;

`ifdef SPI_LOADER_READBACK_EN
    logic                      sck_fall;
    logic                      read_q;
    logic [DATA_LENGTH-1:0]    tx_q;
`else
    logic                      unused_ram_do;
    assign unused_ram_do = ^bus.RAM_Do;
`endif

    // Two-flop synchronizers plus one edge-detect stage. CS_N idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what makes this a real shift chain.
            sck_s1  <= bus.SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= bus.CS_N;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= bus.MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign shift_in = {shift_q[DATA_LENGTH-2:0], mosi_s2};
`ifdef SPI_LOADER_READBACK_EN
    assign sck_fall = ~sck_s2 & sck_s3;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. A deasserted CS_N (synchronized level) returns to IDLE
    // from every state, with two exceptions. A WRITE already underway is
    // allowed to finish. A 32nd data bit that arrives together with the CS_N
    // rise still produces its write.
    always_comb begin
        // NOTE: default first so every path assigns state_d (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cs_fall) state_d = S_CMD;
            S_CMD: begin
                if (cs_s2) state_d = S_IDLE;
                else if (sck_rise && bit_cnt_q == 5'd7) begin
                    if (shift_in[7:0] == CMD_WRITE) state_d = S_ADDR;
`ifdef SPI_LOADER_READBACK_EN
                    else if (shift_in[7:0] == CMD_READ) state_d = S_ADDR;
`endif
                    else state_d = S_IGNORE;
                end
            end
            S_ADDR: begin
                if (cs_s2) state_d = S_IDLE;
                else if (sck_rise && bit_cnt_q == 5'd15) begin
`ifdef SPI_LOADER_READBACK_EN
                    state_d = read_q ? S_RDREQ : S_WDATA;
`else
                    state_d = S_WDATA;
`endif
                end
            end
            S_WDATA: begin
                if (sck_rise && bit_cnt_q == 5'd31) state_d = S_WRITE;
                else if (cs_s2)                     state_d = S_IDLE;
            end
            S_WRITE: state_d = cs_s2 ? S_IDLE : S_WDATA;
`ifdef SPI_LOADER_READBACK_EN
            S_RDREQ:  state_d = cs_s2 ? S_IDLE : S_RDLOAD;
            S_RDLOAD: state_d = cs_s2 ? S_IDLE : S_RDATA;
            S_RDATA: begin
                if (cs_s2) state_d = S_IDLE;
                else if (sck_rise && bit_cnt_q == 5'd31) state_d = S_RDREQ;
            end
`endif
            S_IGNORE: if (cs_s2) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: bit counter, shift registers, address, word count, ACTIVE and
    // the hold registers behind RAM_A/RAM_Di.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            ram_a_q    <= '0;
            ram_di_q   <= '0;
            active_q   <= 1'b0;
            word_cnt_q <= '0;
`ifdef SPI_LOADER_READBACK_EN
            read_q     <= 1'b0;
            tx_q       <= '0;
`endif
        end else begin
            // ACTIVE clears one CLK after the FSM has settled in IDLE.
            if (state_q == S_IDLE) active_q <= cs_fall;

            case (state_q)
                S_IDLE: bit_cnt_q <= '0;
                S_CMD: if (sck_rise) begin
                    shift_q   <= shift_in;
                    bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
`ifdef SPI_LOADER_READBACK_EN
                    if (bit_cnt_q == 5'd7) read_q <= (shift_in[7:0] == CMD_READ);
`endif
                end
                S_ADDR: if (sck_rise) begin
                    shift_q   <= shift_in;
                    bit_cnt_q <= (bit_cnt_q == 5'd15) ? 5'd0 : bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) addr_q <= shift_in[ADDRESS_LENGTH-1:0];
                end
                // The 5-bit counter wraps to 0 on the 32nd bit by itself.
                S_WDATA: if (sck_rise) begin
                    shift_q   <= shift_in;
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
                S_WRITE: begin
                    ram_a_q  <= addr_q;
                    ram_di_q <= shift_q;
                    addr_q   <= addr_q + ADDRESS_LENGTH'(1);
                    if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
                end
`ifdef SPI_LOADER_READBACK_EN
                S_RDREQ:  ram_a_q <= addr_q;
                S_RDLOAD: tx_q    <= bus.RAM_Do;
                // A bit count of zero means bit31 has not been sampled yet.
                // The first fall after a load therefore leaves bit31 on MISO.
                S_RDATA: begin
                    if (sck_rise) begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) addr_q <= addr_q + ADDRESS_LENGTH'(1);
                    end else if (sck_fall && bit_cnt_q != 5'd0) begin
                        tx_q <= {tx_q[DATA_LENGTH-2:0], 1'b0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // RAM port and MISO outputs. Outside an access cycle, RAM_A and RAM_Di
    // keep showing the last address and data that were driven.
    always_comb begin
        bus.RAM_EN = 1'b0;
        bus.RAM_WE = 4'b0000;
        bus.RAM_A  = ram_a_q;
        bus.RAM_Di = ram_di_q;
        bus.MISO   = 1'b0;
        case (state_q)
            S_WRITE: begin
                bus.RAM_EN = 1'b1;
                bus.RAM_WE = 4'b1111;
                bus.RAM_A  = addr_q;
                bus.RAM_Di = shift_q;
            end
`ifdef SPI_LOADER_READBACK_EN
            S_RDREQ: begin
                bus.RAM_EN = 1'b1;
                bus.RAM_A  = addr_q;
            end
            S_RDATA: bus.MISO = tx_q[DATA_LENGTH-1];
`endif
            default: ;
        endcase
    end

    assign ACTIVE   = active_q;
    assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_spi_ram_loader.sv
// tb_spi_ram_loader: bit-banged SPI host plus a behavioural RAM.
// The expected RAM contents, write list and word count come from a
// word-level model that the bench keeps for itself.
module tb_spi_ram_loader;
    localparam int AL    = 11;
    localparam int DL    = 32;
    localparam int DEPTH = 1 << AL;
    localparam int H     = 8;   // CLK cycles per SCK half period

    logic        CLK = 1'b0;
    logic        RST;
    logic        ACTIVE;
    logic [15:0] WORD_CNT;

    spi_ram_loader_if #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(DL)) bus ();

    spi_ram_loader #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(DL)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .ACTIVE   (ACTIVE),
        .WORD_CNT (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data appears the CLK after RAM_EN.
    logic [31:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WE == 4'hF) ram[bus.RAM_A] <= bus.RAM_Di;
            else                    bus.RAM_Do     <= ram[bus.RAM_A];
        end
    end

    // Monitor: one entry per CLK with RAM_EN high.
    typedef struct packed {
        logic [AL-1:0] a;
        logic [31:0]   d;
        logic [3:0]    we;
    } wr_t;
    wr_t wr_q[$];
    int  rd_pulses = 0;
    always @(negedge CLK) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WE != 4'h0) wr_q.push_back({bus.RAM_A, bus.RAM_Di, bus.RAM_WE});
            else                    rd_pulses++;
        end
    end

    // Reference model state.
    logic [31:0] exp_mem [DEPTH];
    int          exp_cnt;
    logic [31:0] wbuf [4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic spi_bit(input logic b, input logic cs_up, output logic m);
        bus.MOSI = b;
        repeat (H) @(negedge CLK);
        m = bus.MISO;
        bus.SCK = 1'b1;
        if (cs_up) bus.CS_N = 1'b1;
        repeat (H) @(negedge CLK);
        bus.SCK = 1'b0;
    endtask

    task automatic spi_field(input logic [31:0] v, input int n, input logic cs_up_last,
                             output logic [31:0] rx);
        logic m;
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], cs_up_last && (i == 0), m);
            rx = {rx[30:0], m};
        end
    endtask

    task automatic frame_start();
        bus.CS_N = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge CLK);
        bus.CS_N = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    // Write frame of n words from wbuf starting at address a (upper bits ignored).
    task automatic do_write(input logic [15:0] a, input int n, input logic cs_with_last,
                            input string tag);
        logic [31:0] rx;
        int          base_w;
        int          base;
        base_w = wr_q.size();
        base   = int'(a) % DEPTH;
        frame_start();
        spi_field(32'h02, 8, 1'b0, rx);
        spi_field({16'h0, a}, 16, 1'b0, rx);
        check($sformatf("%s_active", tag), 64'(ACTIVE), 64'd1);
        for (int i = 0; i < n; i++) begin
            spi_field(wbuf[i], 32, cs_with_last && (i == n - 1), rx);
            exp_mem[(base + i) % DEPTH] = wbuf[i];
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (cs_with_last) repeat (12) @(negedge CLK);
        else              frame_end();
        check($sformatf("%s_nwrites", tag), 64'(wr_q.size() - base_w), 64'(n));
        for (int i = 0; i < n && base_w + i < wr_q.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), 64'(wr_q[base_w + i].a), 64'((base + i) % DEPTH));
            check($sformatf("%s_d%0d", tag, i), 64'(wr_q[base_w + i].d), 64'(wbuf[i]));
            check($sformatf("%s_we%0d", tag, i), 64'(wr_q[base_w + i].we), 64'hF);
        end
        check($sformatf("%s_word_cnt", tag), 64'(WORD_CNT), 64'(exp_cnt));
        check($sformatf("%s_active_end", tag), 64'(ACTIVE), 64'd0);
    endtask

    // Read frame of n words from address a.
    task automatic do_read(input logic [15:0] a, input int n, input string tag);
        logic [31:0] rx;
        logic [31:0] exp_w;
        int          base_w;
        int          base_r;
        int          base;
        base_w = wr_q.size();
        base_r = rd_pulses;
        base   = int'(a) % DEPTH;
        frame_start();
        spi_field(32'h03, 8, 1'b0, rx);
        spi_field({16'h0, a}, 16, 1'b0, rx);
        for (int i = 0; i < n; i++) begin
            spi_field($urandom, 32, 1'b0, rx);
`ifdef SPI_LOADER_READBACK_EN
            exp_w = exp_mem[(base + i) % DEPTH];
`else
            exp_w = 32'h0;
`endif
            check($sformatf("%s_w%0d", tag, i), 64'(rx), 64'(exp_w));
        end
        frame_end();
        check($sformatf("%s_nwrites", tag), 64'(wr_q.size() - base_w), 64'd0);
`ifdef SPI_LOADER_READBACK_EN
        check($sformatf("%s_nreads", tag), 64'(rd_pulses - base_r), 64'(n + 1));
`else
        check($sformatf("%s_nreads", tag), 64'(rd_pulses - base_r), 64'd0);
`endif
        check($sformatf("%s_word_cnt", tag), 64'(WORD_CNT), 64'(exp_cnt));
        check($sformatf("%s_active_end", tag), 64'(ACTIVE), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, 64'(ACTIVE), 64'd0);
        check({tag, "_word_cnt"}, 64'(WORD_CNT), 64'd0);
        check({tag, "_ram_en"}, 64'(bus.RAM_EN), 64'd0);
        check({tag, "_ram_we"}, 64'(bus.RAM_WE), 64'd0);
        check({tag, "_ram_a"}, 64'(bus.RAM_A), 64'd0);
        check({tag, "_ram_di"}, 64'(bus.RAM_Di), 64'd0);
        check({tag, "_miso"}, 64'(bus.MISO), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] miso_or;
        logic [15:0] ra [4];
        int          rn [4];
        int          base_w;
        int          base_r;

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        exp_cnt  = 0;
        bus.SCK  = 1'b0;
        bus.CS_N = 1'b1;
        bus.MOSI = 1'b0;
        RST      = 1'b1;

        // Reset state.
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("post_reset_active", 64'(ACTIVE), 64'd0);

        // Single write.
        wbuf[0] = 32'hDEADBEEF;
        do_write(16'h0010, 1, 1'b0, "single");
        check("single_hold_a", 64'(bus.RAM_A), 64'd16);
        check("single_hold_di", 64'(bus.RAM_Di), 64'hDEADBEEF);

        // Burst across the top of the address space.
        wbuf[0] = 32'h11111111;
        wbuf[1] = 32'h22222222;
        do_write(16'h07FF, 2, 1'b0, "wrap");

        // Abort after 20 data bits: nothing written.
        base_w = wr_q.size();
        frame_start();
        spi_field(32'h02, 8, 1'b0, rx);
        spi_field(32'h0004, 16, 1'b0, rx);
        spi_field($urandom, 20, 1'b0, rx);
        frame_end();
        check("abort_nwrites", 64'(wr_q.size() - base_w), 64'd0);
        check("abort_word_cnt", 64'(WORD_CNT), 64'(exp_cnt));
        check("abort_active", 64'(ACTIVE), 64'd0);
        wbuf[0] = $urandom;
        do_write(16'h0004, 1, 1'b0, "after_abort");

        // Unknown command.
        base_w  = wr_q.size();
        base_r  = rd_pulses;
        miso_or = '0;
        frame_start();
        spi_field(32'hA5, 8, 1'b0, rx);
        miso_or |= rx;
        spi_field(32'h0000, 16, 1'b0, rx);
        miso_or |= rx;
        spi_field(32'hFFFFFFFF, 32, 1'b0, rx);
        miso_or |= rx;
        frame_end();
        check("badcmd_nwrites", 64'(wr_q.size() - base_w), 64'd0);
        check("badcmd_nreads", 64'(rd_pulses - base_r), 64'd0);
        check("badcmd_miso", 64'(miso_or), 64'd0);
        check("badcmd_active", 64'(ACTIVE), 64'd0);

        // Random write frames; the upper address bits are random and must be ignored.
        for (int f = 0; f < 4; f++) begin
            ra[f] = 16'($urandom);
            rn[f] = $urandom_range(1, 3);
            for (int i = 0; i < rn[f]; i++) wbuf[i] = $urandom;
            do_write(ra[f], rn[f], 1'b0, $sformatf("rand%0d", f));
        end

        // CS_N rises together with the 32nd SCK rise: the word is still written.
        wbuf[0] = $urandom;
        do_write(16'($urandom), 1, 1'b1, "cs_with_last");

        // Readback.
        wbuf[0] = 32'h12345678;
        wbuf[1] = 32'hCAFEF00D;
        do_write(16'h0005, 2, 1'b0, "preload");
        do_read(16'h0005, 2, "read56");
        do_read(ra[3], rn[3], "read_rand");

        // Asynchronous reset mid-frame, with the FSM in WDATA.
        frame_start();
        spi_field(32'h02, 8, 1'b0, rx);
        spi_field(32'h0123, 16, 1'b0, rx);
        spi_field($urandom, 10, 1'b0, rx);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_all_zero("midreset");
        bus.CS_N = 1'b1;
        bus.SCK  = 1'b0;
        exp_cnt  = 0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        check("midreset_idle_active", 64'(ACTIVE), 64'd0);
        wbuf[0] = $urandom;
        do_write(16'h0100, 1, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
